// File: rtl/axi_rd_register.sv
// axi_rd_register: pipelined register slice for the AXI4 read address (AR, forward)
// and read data (R, backward) channels, with an optional cap on the number of
// accepted-but-incomplete read bursts.

// One slice stage: a 2-entry skid buffer. Valid and ready toward the neighbours come
// straight from flops, so no combinational path crosses the stage in either direction.
module axi_rd_register_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready
);

  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;
  logic [1:0]   r_fill;
  logic         r_valid;
  logic         r_ready;
  logic         w_push;
  logic         w_pop;
  logic [1:0]   w_fill_nxt;

  assign w_push  = i_valid & r_ready;
  assign w_pop   = r_valid & i_ready;
  assign o_ready = r_ready;
  assign o_valid = r_valid;
  assign o_data  = r_head;

  // Occupancy after this edge's push/pop.
  always_comb begin
    w_fill_nxt = r_fill;
    if (w_push && !w_pop) begin
      w_fill_nxt = r_fill + 2'd1;
    end else if (!w_push && w_pop) begin
      w_fill_nxt = r_fill - 2'd1;
    end
  end

  // Control flops: fill level plus registered valid (not empty) and ready (not full).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill  <= 2'd0;
      r_valid <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_fill  <= w_fill_nxt;
      r_valid <= (w_fill_nxt != 2'd0);
      r_ready <= (w_fill_nxt != 2'd2);
    end
  end

  // Payload flops (never reset): head is presented downstream, tail is the skid slot.
  // A push while full cannot happen because ready is low whenever fill is 2.
  always_ff @(posedge clk) begin
    if (w_pop) begin
      if (r_fill == 2'd2) begin
        r_head <= r_tail;
      end else if (w_push) begin
        r_head <= i_data;
      end
    end else if (w_push) begin
      if (r_fill == 2'd0) begin
        r_head <= i_data;
      end else begin
        r_tail <= i_data;
      end
    end
  end

endmodule

// Top: PIPE_LEVEL skid stages per channel plus the outstanding-burst limiter.
module axi_rd_register #(
  parameter int PIPE_LEVEL      = 3,
  parameter int MAX_OUTSTANDING = 16,
  parameter int ADDR_W          = 32,
  parameter int ID_W            = 4,
  parameter int DATA_W          = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  // initiator side: AR in, R out
  input  logic [ADDR_W-1:0] i_s_araddr,
  input  logic [ID_W-1:0]   i_s_arid,
  input  logic [7:0]        i_s_arlen,
  input  logic [2:0]        i_s_arsize,
  input  logic [1:0]        i_s_arburst,
  input  logic              i_s_arvalid,
  output logic              o_s_arready,
  output logic [DATA_W-1:0] o_s_rdata,
  output logic [1:0]        o_s_rresp,
  output logic              o_s_rlast,
  output logic [ID_W-1:0]   o_s_rid,
  output logic              o_s_rvalid,
  input  logic              i_s_rready,
  // memory side: AR out, R in
  output logic [ADDR_W-1:0] o_m_araddr,
  output logic [ID_W-1:0]   o_m_arid,
  output logic [7:0]        o_m_arlen,
  output logic [2:0]        o_m_arsize,
  output logic [1:0]        o_m_arburst,
  output logic              o_m_arvalid,
  input  logic              i_m_arready,
  input  logic [DATA_W-1:0] i_m_rdata,
  input  logic [1:0]        i_m_rresp,
  input  logic              i_m_rlast,
  input  logic [ID_W-1:0]   i_m_rid,
  input  logic              i_m_rvalid,
  output logic              o_m_rready
);

  localparam int AR_W = ADDR_W + ID_W + 8 + 3 + 2;
  localparam int R_W  = DATA_W + 2 + 1 + ID_W;

  // Index 0 is the entry of a chain, index PIPE_LEVEL its far end.
  logic [AR_W-1:0] w_ar_data  [0:PIPE_LEVEL];
  logic            w_ar_valid [0:PIPE_LEVEL];
  logic            w_ar_ready [0:PIPE_LEVEL];
  logic [R_W-1:0]  w_r_data   [0:PIPE_LEVEL];
  logic            w_r_valid  [0:PIPE_LEVEL];
  logic            w_r_ready  [0:PIPE_LEVEL];
  logic            w_ar_allow;

  // AR enters from the initiator; the limiter gates both the ready and the write enable.
  assign w_ar_data[0]           = {i_s_araddr, i_s_arid, i_s_arlen, i_s_arsize, i_s_arburst};
  assign w_ar_valid[0]          = i_s_arvalid & w_ar_allow;
  assign o_s_arready            = w_ar_ready[0] & w_ar_allow;
  assign {o_m_araddr, o_m_arid, o_m_arlen, o_m_arsize, o_m_arburst} = w_ar_data[PIPE_LEVEL];
  assign o_m_arvalid            = w_ar_valid[PIPE_LEVEL];
  assign w_ar_ready[PIPE_LEVEL] = i_m_arready;

  // R enters from memory and flows back to the initiator.
  assign w_r_data[0]            = {i_m_rdata, i_m_rresp, i_m_rlast, i_m_rid};
  assign w_r_valid[0]           = i_m_rvalid;
  assign o_m_rready             = w_r_ready[0];
  assign {o_s_rdata, o_s_rresp, o_s_rlast, o_s_rid} = w_r_data[PIPE_LEVEL];
  assign o_s_rvalid             = w_r_valid[PIPE_LEVEL];
  assign w_r_ready[PIPE_LEVEL]  = i_s_rready;

  for (genvar g = 0; g < PIPE_LEVEL; g++) begin : g_stage
    axi_rd_register_stage #(.W(AR_W)) u_ar (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_data  (w_ar_data[g]),
      .i_valid (w_ar_valid[g]),
      .o_ready (w_ar_ready[g]),
      .o_data  (w_ar_data[g+1]),
      .o_valid (w_ar_valid[g+1]),
      .i_ready (w_ar_ready[g+1])
    );
    axi_rd_register_stage #(.W(R_W)) u_r (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_data  (w_r_data[g]),
      .i_valid (w_r_valid[g]),
      .o_ready (w_r_ready[g]),
      .o_data  (w_r_data[g+1]),
      .o_valid (w_r_valid[g+1]),
      .i_ready (w_r_ready[g+1])
    );
  end

  if (MAX_OUTSTANDING > 0) begin : g_limit
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] r_cnt;
    logic             w_inc;
    logic             w_dec;

    assign w_inc      = i_s_arvalid & o_s_arready;
    assign w_dec      = o_s_rvalid & i_s_rready & o_s_rlast;
    // r_cnt is a flop, so this gate adds no valid-to-ready path.
    assign w_ar_allow = (r_cnt != CNT_MAX);

    // Outstanding-burst count: up on AR accept, down on final R beat, floor at zero.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (w_inc && !w_dec) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (w_dec && !w_inc && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end

    // Flag a burst completion that has no matching accepted request.
    always_ff @(posedge clk) begin
      if (rst_n) begin
        assert (!(w_dec && (r_cnt == '0)));
      end
    end
  end else begin : g_nolimit
    assign w_ar_allow = 1'b1;
  end

endmodule
